// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong game-state engine.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } game_state_t;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_X_L   = 16;
    localparam int DEF_PADDLE_X_R   = 616;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_SPEED = 4;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_SCORE_MAX    = 9;

    localparam int BALL_X_CENTRE   = DEF_H_RES / 2 - DEF_BALL_SIZE / 2;
    localparam int BALL_Y_CENTRE   = DEF_V_RES / 2 - DEF_BALL_SIZE / 2;
    localparam int PADDLE_Y_CENTRE = (DEF_V_RES - DEF_PADDLE_H) / 2;

endpackage

// File: rtl/pong_if.sv
// Per-frame game state handed from the engine to the renderer.
interface pong_if;
    logic [10:0]              ball_x;
    logic [10:0]              ball_y;
    logic [10:0]              pad_l_y;
    logic [10:0]              pad_r_y;
    logic [3:0]               score_l;
    logic [3:0]               score_r;
    pong_pkg::game_state_t    state;
    logic                     game_over;

    modport master (output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, game_over);
    modport slave  (input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, game_over);
endinterface

// File: rtl/pong_paddle.sv
// One paddle: steps up/down once per frame tick, clamped to the screen.
module pong_paddle #(
    parameter int          V_RES    = 480,
    parameter int          PADDLE_H = 64,
    parameter int          SPEED    = 4,
    parameter logic [10:0] Y_INIT   = 11'd208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        up,
    input  logic        dn,
    input  logic        tick,
    input  logic        enable,
    input  logic        reload,
    output logic [10:0] y
);
    localparam logic [11:0] STEP  = 12'(SPEED);
    localparam logic [11:0] Y_MAX = 12'(V_RES - PADDLE_H);

    logic [10:0] y_reg, y_next;
    logic [11:0] y_w, y_dn;

    // Compare in 12 bits so the step can never wrap past either edge.
    always_comb begin
        y_next = y_reg;
        y_w    = {1'b0, y_reg};
        y_dn   = y_w + STEP;
        if (reload) begin
            y_next = Y_INIT;
        end else if (tick && enable && (up != dn)) begin
            if (up) y_next = (y_w < STEP) ? 11'd0 : y_reg - STEP[10:0];
            else    y_next = (y_dn > Y_MAX) ? Y_MAX[10:0] : y_dn[10:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_reg <= Y_INIT;
        else        y_reg <= y_next;
    end

    assign y = y_reg;
endmodule

// File: rtl/pong_game.sv
// Pong game-state engine: advances ball, paddles and scores once per vsync
// rising edge and runs the serve/play/game-over sequence.
module pong_game
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_X_L   = DEF_PADDLE_X_L,
    parameter int PADDLE_X_R   = DEF_PADDLE_X_R,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int SCORE_MAX    = DEF_SCORE_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [3:0] btn,
    input  logic       start,
    pong_if.master     game
);
    localparam int          CNT_W    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SERVE_FRAMES);
    localparam logic [10:0] BALL_X0  = 11'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [10:0] BALL_Y0  = 11'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic [10:0] PAD_Y0   = 11'((V_RES - PADDLE_H) / 2);
    localparam logic [11:0] STEP     = 12'(BALL_SPEED);
    localparam logic [11:0] BSZ      = 12'(BALL_SIZE);
    localparam logic [11:0] PAD_H    = 12'(PADDLE_H);
    localparam logic [11:0] Y_LIMIT  = 12'(V_RES - BALL_SIZE);
    localparam logic [11:0] X_LIMIT  = 12'(H_RES - BALL_SIZE);
    localparam logic [11:0] FACE_L   = 12'(PADDLE_X_L + PADDLE_W);
    localparam logic [11:0] FACE_R   = 12'(PADDLE_X_R);
    localparam logic [11:0] HIT_R_X  = 12'(PADDLE_X_R - BALL_SIZE);
    localparam logic [3:0]  SCORE_TOP = 4'(SCORE_MAX);

    logic [3:0]  btn_s1, btn_s2;
    logic        start_s1, start_s2, start_d, vsync_d;
    logic        tick, start_rise, paddle_en, paddle_reload;

    game_state_t      state_reg, state_next;
    logic [CNT_W-1:0] serve_cnt_reg, serve_cnt_next;
    logic [10:0]      ball_x_reg, ball_x_next, ball_y_reg, ball_y_next;
    logic             dx_reg, dx_next, dy_reg, dy_next;   // 1 = increasing coordinate
    logic [3:0]       score_l_reg, score_l_next, score_r_reg, score_r_next;
    logic [10:0]      pad_y [2];

    logic [11:0] bx, by, nx, ny, pl, pr;
    logic        overlap_l, overlap_r, miss_l, miss_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            vsync_d  <= 1'b0;
        end else begin
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            start_s1 <= start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            vsync_d  <= vsync;
        end
    end

    assign tick          = vsync & ~vsync_d;
    assign start_rise    = start_s2 & ~start_d;
    assign paddle_en     = (state_reg != OVER);
    assign paddle_reload = (state_reg == OVER) && start_rise;

    // Side gi uses btn bits {dn, up} = {2*gi+1, 2*gi}.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_paddle
            pong_paddle #(
                .V_RES    (V_RES),
                .PADDLE_H (PADDLE_H),
                .SPEED    (PADDLE_SPEED),
                .Y_INIT   (PAD_Y0)
            ) u_paddle (
                .clk    (clk),
                .rst_n  (rst_n),
                .up     (btn_s2[2*gi]),
                .dn     (btn_s2[2*gi+1]),
                .tick   (tick),
                .enable (paddle_en),
                .reload (paddle_reload),
                .y      (pad_y[gi])
            );
        end
    endgenerate

    assign bx        = {1'b0, ball_x_reg};
    assign by        = {1'b0, ball_y_reg};
    assign pl        = {1'b0, pad_y[0]};
    assign pr        = {1'b0, pad_y[1]};
    assign overlap_l = (by + BSZ > pl) && (by < pl + PAD_H);
    assign overlap_r = (by + BSZ > pr) && (by < pr + PAD_H);

    always_comb begin
        state_next     = state_reg;
        serve_cnt_next = serve_cnt_reg;
        ball_x_next    = ball_x_reg;
        ball_y_next    = ball_y_reg;
        dx_next        = dx_reg;
        dy_next        = dy_reg;
        score_l_next   = score_l_reg;
        score_r_next   = score_r_reg;
        miss_l         = 1'b0;
        miss_r         = 1'b0;
        nx             = '0;
        ny             = '0;
        case (state_reg)
            SERVE: if (tick) begin
                if (serve_cnt_reg == '0) state_next = PLAY;
                else                     serve_cnt_next = serve_cnt_reg - 1'b1;
            end
            PLAY: if (tick) begin
                if (dy_reg) begin
                    ny = by + STEP;
                    if (ny > Y_LIMIT) begin
                        ball_y_next = Y_LIMIT[10:0];
                        dy_next     = 1'b0;
                    end else begin
                        ball_y_next = ny[10:0];
                    end
                end else if (by < STEP) begin
                    ball_y_next = '0;
                    dy_next     = 1'b1;
                end else begin
                    ny          = by - STEP;
                    ball_y_next = ny[10:0];
                end
                if (!dx_reg) begin
                    nx = bx - STEP;
                    if (bx >= FACE_L && nx <= FACE_L && overlap_l) begin
                        ball_x_next = FACE_L[10:0];
                        dx_next     = 1'b1;
                    end else if (bx < STEP) begin
                        miss_l = 1'b1;
                    end else begin
                        ball_x_next = nx[10:0];
                    end
                end else begin
                    nx = bx + STEP;
                    if (bx + BSZ <= FACE_R && nx + BSZ >= FACE_R && overlap_r) begin
                        ball_x_next = HIT_R_X[10:0];
                        dx_next     = 1'b0;
                    end else if (nx > X_LIMIT) begin
                        miss_r = 1'b1;
                    end else begin
                        ball_x_next = nx[10:0];
                    end
                end
                // A miss keeps the ball's x; the serve goes toward whoever conceded.
                if (miss_l || miss_r) begin
                    if (miss_l && score_r_reg != SCORE_TOP) score_r_next = score_r_reg + 4'd1;
                    if (miss_r && score_l_reg != SCORE_TOP) score_l_next = score_l_reg + 4'd1;
                    if (score_l_next == SCORE_TOP || score_r_next == SCORE_TOP) begin
                        state_next = OVER;
                    end else begin
                        state_next     = SERVE;
                        ball_x_next    = BALL_X0;
                        ball_y_next    = BALL_Y0;
                        serve_cnt_next = CNT_INIT;
                        dx_next        = miss_r;
                    end
                end
            end
            OVER: if (start_rise) begin
                state_next     = SERVE;
                serve_cnt_next = CNT_INIT;
                ball_x_next    = BALL_X0;
                ball_y_next    = BALL_Y0;
                dx_next        = 1'b1;
                dy_next        = 1'b1;
                score_l_next   = '0;
                score_r_next   = '0;
            end
            default: state_next = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SERVE;
            serve_cnt_reg <= CNT_INIT;
            ball_x_reg    <= BALL_X0;
            ball_y_reg    <= BALL_Y0;
            dx_reg        <= 1'b1;
            dy_reg        <= 1'b1;
            score_l_reg   <= '0;
            score_r_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            serve_cnt_reg <= serve_cnt_next;
            ball_x_reg    <= ball_x_next;
            ball_y_reg    <= ball_y_next;
            dx_reg        <= dx_next;
            dy_reg        <= dy_next;
            score_l_reg   <= score_l_next;
            score_r_reg   <= score_r_next;
        end
    end

    assign game.ball_x    = ball_x_reg;
    assign game.ball_y    = ball_y_reg;
    assign game.pad_l_y   = pad_y[0];
    assign game.pad_r_y   = pad_y[1];
    assign game.score_l   = score_l_reg;
    assign game.score_r   = score_r_reg;
    assign game.state     = state_reg;
    assign game.game_over = (state_reg == OVER);
endmodule

// File: tb/tb_pong_game.sv
// Bench for pong_game: fixed vector table, steered/random play against a
// behavioural game model, and hand sequences for reset, idle vsync and restart.
module tb_pong_game;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic [3:0] btn;
    logic       start;

    pong_if game_if ();

    pong_game dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .btn   (btn),
        .start (start),
        .game  (game_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    // Behavioural model: positions in pixels, velocities as signed pixel steps.
    int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt, m_vx, m_vy;

    localparam int TRACK = 0;
    localparam int AVOID = 1;

    typedef struct {
        int         frames;
        logic [3:0] b;
        int         bx, by, pl, pr, st;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ball_x"},    int'(game_if.ball_x),    m_bx);
        check({tag, ".ball_y"},    int'(game_if.ball_y),    m_by);
        check({tag, ".pad_l_y"},   int'(game_if.pad_l_y),   m_pl);
        check({tag, ".pad_r_y"},   int'(game_if.pad_r_y),   m_pr);
        check({tag, ".score_l"},   int'(game_if.score_l),   m_sl);
        check({tag, ".score_r"},   int'(game_if.score_r),   m_sr);
        check({tag, ".state"},     int'(game_if.state),     m_st);
        check({tag, ".game_over"}, int'(game_if.game_over), (m_st == 2) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_bx = BALL_X_CENTRE;   m_by = BALL_Y_CENTRE;
        m_pl = PADDLE_Y_CENTRE; m_pr = PADDLE_Y_CENTRE;
        m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 60; m_vx = 2; m_vy = 2;
    endtask

    function automatic int pad_move(input int p, input logic up, input logic dn);
        if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
        if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
        return p;
    endfunction

    function automatic bit covers(input int pad);
        return (m_by + 8 > pad) && (m_by < pad + 64);
    endfunction

    task automatic model_tick(input logic [3:0] b);
        int  nx, ny;
        bit  lost_l, lost_r;
        if (m_st == 2) return;
        if (m_st == 0) begin
            if (m_cnt == 0) m_st = 1;
            else            m_cnt--;
        end else begin
            ny = m_by + m_vy;
            if (ny < 0)        begin ny = 0;   m_vy = 2;  end
            else if (ny > 472) begin ny = 472; m_vy = -2; end
            nx = m_bx + m_vx;
            lost_l = 0; lost_r = 0;
            if (m_vx < 0) begin
                if (m_bx >= 24 && nx <= 24 && covers(m_pl)) begin nx = 24; m_vx = 2; end
                else if (nx < 0) lost_l = 1;
            end else begin
                if (m_bx + 8 <= 616 && nx + 8 >= 616 && covers(m_pr)) begin nx = 608; m_vx = -2; end
                else if (nx + 8 > 640) lost_r = 1;
            end
            m_by = ny;
            if (lost_l || lost_r) begin
                if (lost_l) m_sr++;
                else        m_sl++;
                if (m_sl == 9 || m_sr == 9) begin
                    m_st = 2;
                end else begin
                    m_st = 0; m_cnt = 60;
                    m_bx = BALL_X_CENTRE; m_by = BALL_Y_CENTRE;
                    m_vx = lost_l ? -2 : 2;
                end
            end else begin
                m_bx = nx;
            end
        end
        m_pl = pad_move(m_pl, b[0], b[1]);
        m_pr = pad_move(m_pr, b[2], b[3]);
    endtask

    task automatic model_start();
        if (m_st != 2) return;
        model_reset();
    endtask

    function automatic logic [1:0] steer_side(input int mode, input int pad);
        if (mode == AVOID) return (m_by > 240) ? 2'b01 : 2'b10;
        if (m_by + 4 > pad + 36) return 2'b10;
        if (m_by + 4 < pad + 28) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] steer(input int mode_l, input int mode_r);
        return {steer_side(mode_r, m_pr), steer_side(mode_l, m_pl)};
    endfunction

    // One frame: buttons settle through the synchroniser, then a vsync pulse;
    // outputs must carry the new frame one clock after vsync rises.
    task automatic frame(input logic [3:0] b);
        @(negedge clk);
        btn = b;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        model_tick(b);
        @(posedge clk);
        #1;
        frame_no++;
        $display("frame %0d btn=%b ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d state=%0d",
                 frame_no, b, game_if.ball_x, game_if.ball_y, game_if.pad_l_y,
                 game_if.pad_r_y, game_if.score_l, game_if.score_r, game_if.state);
        check_all("frame");
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int prev_sr;

        vecs[0] = '{0,  4'b0000, 316, 236, 208, 208, 0};
        vecs[1] = '{60, 4'b0000, 316, 236, 208, 208, 0};
        vecs[2] = '{1,  4'b0000, 316, 236, 208, 208, 1};
        vecs[3] = '{1,  4'b0000, 318, 238, 208, 208, 1};
        vecs[4] = '{52, 4'b0001, 422, 342, 0,   208, 1};
        vecs[5] = '{8,  4'b0001, 438, 358, 0,   208, 1};
        vecs[6] = '{5,  4'b0011, 448, 368, 0,   208, 1};
        vecs[7] = '{5,  4'b0010, 458, 378, 20,  208, 1};
        vecs[8] = '{10, 4'b1000, 478, 398, 20,  248, 1};

        rst_n = 1'b1; vsync = 1'b0; btn = 4'b0; start = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            for (int f = 0; f < vecs[i].frames; f++) frame(vecs[i].b);
            @(negedge clk);
            $display("vector %0d frames=%0d btn=%b ball=(%0d,%0d) pads=%0d/%0d state=%0d",
                     i, vecs[i].frames, vecs[i].b, game_if.ball_x, game_if.ball_y,
                     game_if.pad_l_y, game_if.pad_r_y, game_if.state);
            check($sformatf("vec%0d.ball_x", i),  int'(game_if.ball_x),  vecs[i].bx);
            check($sformatf("vec%0d.ball_y", i),  int'(game_if.ball_y),  vecs[i].by);
            check($sformatf("vec%0d.pad_l_y", i), int'(game_if.pad_l_y), vecs[i].pl);
            check($sformatf("vec%0d.pad_r_y", i), int'(game_if.pad_r_y), vecs[i].pr);
            check($sformatf("vec%0d.state", i),   int'(game_if.state),   vecs[i].st);
        end

        // No vsync edge for 1000 clocks: nothing may move.
        btn = 4'b1010;
        repeat (1000) @(negedge clk);
        $display("idle 1000 clk ball=(%0d,%0d)", game_if.ball_x, game_if.ball_y);
        check_all("idle");

        // vsync held high for a long time yields exactly one tick.
        btn = 4'b0000;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        model_tick(4'b0000);
        repeat (200) @(negedge clk);
        vsync = 1'b0;
        $display("long vsync ball=(%0d,%0d)", game_if.ball_x, game_if.ball_y);
        check_all("long_vsync");

        pulse_start();
        $display("start in PLAY state=%0d", game_if.state);
        check_all("start_ignored_play");

        // Asynchronous reset mid-PLAY, checked before the next clock edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        $display("async reset ball=(%0d,%0d) state=%0d", game_if.ball_x, game_if.ball_y, game_if.state);
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) frame(4'($urandom_range(0, 15)));

        // Right paddle returns the ball, left paddle dodges it.
        prev_sr = m_sr;
        for (int i = 0; i < 1500 && m_sr == prev_sr; i++) frame(steer(AVOID, TRACK));
        $display("rally done score_r=%0d state=%0d", game_if.score_r, game_if.state);
        check("rally_score_r", int'(game_if.score_r), prev_sr + 1);
        check("rally_state", int'(game_if.state), 0);
        for (int i = 0; i < 62; i++) frame(4'b0000);
        check("serve_toward_left", int'(game_if.ball_x), 314);

        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && m_st != 2; i++) frame(steer(AVOID, AVOID));
        $display("game over score=%0d:%0d state=%0d", game_if.score_l, game_if.score_r, game_if.state);
        check("over_state", int'(game_if.state), 2);
        check("over_flag", int'(game_if.game_over), 1);
        check("over_score_l", int'(game_if.score_l), 9);
        check("over_score_r", int'(game_if.score_r), 0);

        for (int i = 0; i < 5; i++) frame(4'($urandom_range(0, 15)));

        pulse_start();
        model_start();
        $display("restart state=%0d score=%0d:%0d", game_if.state, game_if.score_l, game_if.score_r);
        check_all("restart");
        check("restart_score_l", int'(game_if.score_l), 0);
        check("restart_state", int'(game_if.state), 0);

        frame(4'b0000);
        pulse_start();
        $display("start in SERVE state=%0d", game_if.state);
        check_all("start_ignored_serve");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
